cdf_bucket_search: RTL and testbench

- Forward (value → CDF) counterpart of the ICDF lookup in the Sobol/Gaussian path.
- Takes a 13-bit sign-magnitude Gaussian sample and returns the 32-bit uniform CDF code whose ICDF lookup reproduces that sample.
- Uses a 6-step sequential binary search over the same 64-entry magnitude table, with valid/ready handshakes on both sides.
- Used to self-check the ICDF path and to re-map externally supplied samples into the Sobol CDF domain.

---
 rtl/cdf_bucket_search.sv | 112 +++++++++++
 tb/tb_cdf_bucket_search.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdf_bucket_search.sv
// cdf_bucket_search
//   Forward (value -> CDF) map for the Sobol/Gaussian path. A 13-bit
//   sign-magnitude sample is located in the 64-entry magnitude table by a
//   6-step sequential binary search. The result is the bucket-midpoint CDF
//   code whose ICDF lookup gives back the same sample.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   input handshake (in_ready high only in IDLE)
//   sample[12:0]        bit12 = sign (1 = negative), [11:0] = magnitude
//   out_valid/out_ready output handshake (out_valid high only in DONE)
//   cdf[31:0]           {gt, index, 1'b1, 24'h0}
//   index[5:0]          bucket index (== cdf[30:25])
//   sat                 magnitude above the last table entry (clamped)
module cdf_bucket_search #(
  parameter logic [767:0] MAG_LUT = {
    12'h02a, 12'h024, 12'h021, 12'h01e, 12'h01c, 12'h01b, 12'h01a, 12'h019,
    12'h018, 12'h017, 12'h016, 12'h015, 12'h014, 12'h014, 12'h013, 12'h012,
    12'h012, 12'h011, 12'h010, 12'h010, 12'h00f, 12'h00f, 12'h00e, 12'h00e,
    12'h00d, 12'h00d, 12'h00d, 12'h00c, 12'h00c, 12'h00b, 12'h00b, 12'h00a,
    12'h00a, 12'h00a, 12'h009, 12'h009, 12'h009, 12'h008, 12'h008, 12'h007,
    12'h007, 12'h007, 12'h006, 12'h006, 12'h006, 12'h005, 12'h005, 12'h005,
    12'h004, 12'h004, 12'h004, 12'h003, 12'h003, 12'h003, 12'h002, 12'h002,
    12'h002, 12'h002, 12'h001, 12'h001, 12'h001, 12'h000, 12'h000, 12'h000}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] cdf,
  output logic [5:0]  index,
  output logic        sat
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state, state_nxt;

  logic [11:0] lut [64];
  for (genvar g = 0; g < 64; g++) begin : g_lut
    assign lut[g] = MAG_LUT[12*g+11 -: 12];
  end

  logic        neg;
  logic [11:0] mag;
  logic [5:0]  j, t, j_nxt, idx_res;
  logic [2:0]  b;

  // Probe index: set the current bit on top of the prefix found so far.
  // Since M[0] = 0, the final j is the largest index with M[j] <= mag.
  assign t       = j | (6'd1 << b);
  assign j_nxt   = (lut[t] <= mag) ? t : j;
  // 63 - j for a 6-bit value is just its complement.
  assign idx_res = neg ? ~j_nxt : j_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SEARCH;
      SEARCH:  if (b == 3'd0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Search datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg   <= 1'b0;
      mag   <= '0;
      j     <= '0;
      b     <= 3'd5;
      cdf   <= '0;
      index <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          neg <= sample[12];
          mag <= sample[11:0];
          j   <= '0;
          b   <= 3'd5;
        end
        SEARCH: begin
          j <= j_nxt;
          b <= b - 3'd1;
          if (b == 3'd0) begin
            index <= idx_res;
            cdf   <= {~neg, idx_res, 1'b1, 24'h000000};
            sat   <= (mag > lut[63]);
          end
        end
        default: ;  // DONE: results held, even after the handshake
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_bucket_search.sv
module tb_cdf_bucket_search;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [12:0] sample;
  logic        in_ready, out_valid, sat;
  logic [31:0] cdf;
  logic [5:0]  index;

  int tests = 0;
  int fails = 0;
  logic [11:0] tbl [64];

  cdf_bucket_search dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sample(sample), .out_valid(out_valid), .out_ready(out_ready),
    .cdf(cdf), .index(index), .sat(sat)
  );

  always #5 clk = ~clk;

  // Table built from its run-length description.
  task automatic build_table();
    int vals [33] = '{'h00,'h01,'h02,'h03,'h04,'h05,'h06,'h07,'h08,'h09,'h0a,
                      'h0b,'h0c,'h0d,'h0e,'h0f,'h10,'h11,'h12,'h13,'h14,'h15,
                      'h16,'h17,'h18,'h19,'h1a,'h1b,'h1c,'h1e,'h21,'h24,'h2a};
    int cnts [33] = '{3,3,4,3,3,3,3,3,2,3,3,2,2,3,2,2,2,1,2,1,2,1,1,1,1,1,1,1,1,
                      1,1,1,1};
    int p = 0;
    for (int r = 0; r < 33; r++)
      for (int k = 0; k < cnts[r]; k++) begin
        tbl[p] = 12'(vals[r]);
        p++;
      end
  endtask

  // Reference: linear scan for the last bucket whose value fits.
  function automatic void ref_model(input logic [12:0] s, output logic [31:0] c,
                                    output logic [5:0] idx, output logic st);
    int best = 0;
    for (int k = 0; k < 64; k++) if (tbl[k] <= s[11:0]) best = k;
    idx = s[12] ? 6'(63 - best) : 6'(best);
    c   = {~s[12], idx, 1'b1, 24'h000000};
    st  = (s[11:0] > tbl[63]);
  endfunction

  function automatic logic [12:0] icdf(input logic [31:0] c);
    int i = int'(c[30:25]);
    return c[31] ? {1'b0, tbl[i]} : {1'b1, tbl[63 - i]};
  endfunction

  // Drive one sample (called at posedge+1), wait for out_valid.
  task automatic xact(input logic [12:0] s, output int lat, output bit to,
                      output time t_acc);
    int k = 0;
    to = 1'b0;
    in_valid = 1'b1;
    sample   = s;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) to = 1'b1;
    @(posedge clk);
    t_acc = $time;
    #1 in_valid = 1'b0;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) to = 1'b1;
  endtask

  task automatic test_reset();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cdf !== 32'h0 ||
        index !== 6'h0 || sat !== 1'b0) begin
      fails++;
      $display("FAIL reset: ov=%b ir=%b cdf=%h idx=%0d sat=%b, want 0 1 0 0 0",
               out_valid, in_ready, cdf, index, sat);
    end
  endtask

  task automatic test_directed();
    logic [12:0] vec [7] = '{13'h0000, 13'h001d, 13'h002a, 13'h0050,
                             13'h102a, 13'h1000, 13'h0fff};
    logic [31:0] ec; logic [5:0] ei; logic es;
    int lat; bit to; time ta;
    for (int v = 0; v < 7; v++) begin
      ref_model(vec[v], ec, ei, es);
      xact(vec[v], lat, to, ta);
      tests++;
      if (to || lat != 6) begin
        fails++;
        $display("FAIL directed_latency %h: got %0d (timeout=%b), want 6", vec[v], lat, to);
      end
      tests++;
      if (cdf !== ec || index !== ei || sat !== es) begin
        fails++;
        $display("FAIL directed_result %h: cdf=%h idx=%0d sat=%b, want %h %0d %b",
                 vec[v], cdf, index, sat, ec, ei, es);
      end
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || cdf !== ec || index !== ei) begin
        fails++;
        $display("FAIL directed_handshake %h: ov=%b ir=%b cdf=%h idx=%0d, want 0 1 %h %0d",
                 vec[v], out_valid, in_ready, cdf, index, ec, ei);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ec; logic [5:0] ei; logic es;
    int lat; bit to; time ta;
    ref_model(13'h1011, ec, ei, es);
    xact(13'h1011, lat, to, ta);
    for (int n = 0; n < 10; n++) begin
      in_valid = 1'($urandom);
      sample   = 13'($urandom);
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || cdf !== ec || index !== ei) begin
        fails++;
        $display("FAIL backpressure cyc%0d: ov=%b ir=%b cdf=%h idx=%0d, want 1 0 %h %0d",
                 n, out_valid, in_ready, cdf, index, ec, ei);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release: ov=%b ir=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] ec; logic [5:0] ei; logic es;
    int lat; bit to; time ta;
    in_valid = 1'b1;
    sample   = 13'h0033;
    @(posedge clk); #1 in_valid = 1'b0;   // accepted, SEARCH begins
    @(posedge clk); #1;
    @(posedge clk); #1;                   // third SEARCH cycle
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cdf !== 32'h0 ||
        index !== 6'h0 || sat !== 1'b0) begin
      fails++;
      $display("FAIL midreset_async: ov=%b ir=%b cdf=%h idx=%0d sat=%b, want 0 1 0 0 0",
               out_valid, in_ready, cdf, index, sat);
    end
    @(posedge clk); #1 rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_release: ov=%b ir=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    ref_model(13'h0005, ec, ei, es);
    xact(13'h0005, lat, to, ta);
    tests++;
    if (to || lat != 6 || cdf !== ec || index !== ei || sat !== es) begin
      fails++;
      $display("FAIL midreset_fresh: lat=%0d to=%b cdf=%h idx=%0d sat=%b, want 6 0 %h %0d %b",
               lat, to, cdf, index, sat, ec, ei, es);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] c, ec; logic [5:0] ei; logic es; logic [12:0] s;
    int lat; bit to; time ta, tprev;
    bit first = 1'b1;
    out_ready = 1'b1;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 64; i++) begin
        c = {1'(g), 6'(i), 25'($urandom)};
        s = icdf(c);
        ref_model(s, ec, ei, es);
        xact(s, lat, to, ta);
        tests++;
        if (to || icdf(cdf) !== s || cdf !== ec) begin
          fails++;
          $display("FAIL sweep c=%h: s=%h cdf=%h icdf=%h to=%b, want cdf %h",
                   c, s, cdf, icdf(cdf), to, ec);
        end
        if (!first) begin
          tests++;
          if (ta - tprev != 80) begin
            fails++;
            $display("FAIL sweep_ii c=%h: got %0t, want 80", c, ta - tprev);
          end
        end
        first = 1'b0;
        tprev = ta;
      end
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] ec; logic [5:0] ei; logic es; logic [12:0] s;
    int lat; bit to; time ta;
    for (int n = 0; n < 30; n++) begin
      s = {1'($urandom), ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                                    : 12'($urandom_range(0, 63))};
      ref_model(s, ec, ei, es);
      xact(s, lat, to, ta);
      tests++;
      if (to || lat != 6 || cdf !== ec || index !== ei || sat !== es) begin
        fails++;
        $display("FAIL random %h: lat=%0d to=%b cdf=%h idx=%0d sat=%b, want 6 0 %h %0d %b",
                 s, lat, to, cdf, index, sat, ec, ei, es);
      end
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sample = '0;
    build_table();
    #12;
    test_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
